// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache (8 blocks x 4 bytes)
// with its miss-handling FSM between an 8-bit CPU and a word-wide memory.
module dcache_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned BLOCK_W    = 32;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

  state_t state, next_state;

  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [BLOCK_W-1:0]    refill_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [OFF_W-1:0] offset;
  logic [4:0]       byte_lsb;
  logic             hit;
  logic             req;

  assign tag      = address[7:5];
  assign index    = address[4:2];
  assign offset   = address[1:0];
  assign byte_lsb = {offset, 3'b000};
  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign req      = read | write;

  // State, refill latch and block array updates
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      refill_q <= '0;
    end else begin
      state <= next_state;
      if (state == MEM_READ && !mem_busywait) begin
        refill_q <= mem_readdata;
      end
      if (state == UPDATE) begin
        data_q[index]  <= refill_q;
        tag_q[index]   <= tag;
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (state == IDLE && write && hit) begin
        data_q[index][byte_lsb +: BYTE_W] <= writedata;
        dirty_q[index]                    <= 1'b1;
      end
    end
  end

  // Next state and output decode; everything is forced low while in reset
  always_comb begin
    next_state    = state;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    readdata      = '0;
    if (!RESET) begin
      case (state)
        IDLE: begin
          busywait = req & ~hit;
          if (read && !write && hit) begin
            readdata = data_q[index][byte_lsb +: BYTE_W];
          end
          if (req && !hit) begin
            next_state = (valid_q[index] && dirty_q[index]) ? WRITE_BACK : MEM_READ;
          end
        end
        WRITE_BACK: begin
          busywait      = 1'b1;
          mem_write     = 1'b1;
          mem_address   = {tag_q[index], index};
          mem_writedata = data_q[index];
          if (!mem_busywait) begin
            next_state = MEM_READ;
          end
        end
        MEM_READ: begin
          busywait    = 1'b1;
          mem_read    = 1'b1;
          mem_address = {tag, index};
          if (!mem_busywait) begin
            next_state = UPDATE;
          end
        end
        UPDATE: begin
          busywait   = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: latency-5 memory model plus a transaction-level
// cache reference model, directed scenarios then randomized accesses.
module tb_dcache_controller;

  logic        clk;
  logic        RESET;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  dcache_controller dut (
    .CLK          (clk),
    .RESET        (RESET),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  localparam int unsigned MEM_LAT = 5;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: busy for MEM_LAT cycles from the first cycle of each request
  logic [31:0] mem      [64];
  logic [31:0] init_val [64];
  logic        load_mem;
  logic [2:0]  req_cnt = '0;

  assign mem_busywait = (mem_read | mem_write) && (req_cnt < 3'(MEM_LAT));
  assign mem_readdata = mem[mem_address];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
      req_cnt <= '0;
    end else if (mem_read | mem_write) begin
      if (req_cnt == 3'(MEM_LAT)) begin
        if (mem_write) mem[mem_address] <= mem_writedata;
        req_cnt <= '0;
      end else begin
        req_cnt <= req_cnt + 3'd1;
      end
    end else begin
      req_cnt <= '0;
    end
  end

  // Reference cache state and reference memory image
  logic [31:0] ref_data [8];
  logic [2:0]  ref_tag  [8];
  logic [7:0]  ref_valid;
  logic [7:0]  ref_dirty;
  logic [31:0] ref_mem  [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    ref_valid = '0;
    ref_dirty = '0;
  endtask

  // One CPU access; call at posedge+1, returns at posedge+1 after the serving cycle
  task automatic access(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] wd);
    logic [2:0]  idx, tg;
    int          off;
    logic        exp_hit, exp_dirty;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [7:0]  exp_rd;
    int          exp_stall;
    int          stall, nrd, nwr;
    logic [5:0]  rd_addr, wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  got_rd;
    bit          done;

    idx = a[4:2];
    tg  = a[7:5];
    off = int'(a[1:0]);
    exp_hit     = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_dirty   = !exp_hit && ref_valid[idx] && ref_dirty[idx];
    exp_wb_addr = {ref_tag[idx], idx};
    exp_wb_data = ref_data[idx];
    exp_stall   = exp_hit ? 0 : (exp_dirty ? 2 * MEM_LAT + 4 : MEM_LAT + 3);
    if (!exp_hit) begin
      if (exp_dirty) ref_mem[exp_wb_addr] = exp_wb_data;
      ref_data[idx]  = ref_mem[{tg, idx}];
      ref_tag[idx]   = tg;
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
    end
    exp_rd = ref_data[idx][off*8 +: 8];
    if (wr) begin
      ref_data[idx][off*8 +: 8] = wd;
      ref_dirty[idx] = 1'b1;
    end

    read = rd; write = wr; address = a; writedata = wd;
    stall = 0; nrd = 0; nwr = 0; rd_addr = '0; wb_addr = '0; wb_data = '0;
    got_rd = '0; done = 0;
    while (!done && stall < 40) begin
      @(negedge clk);
      if (busywait) begin
        stall++;
        if (mem_read) begin
          if (nrd == 0) rd_addr = mem_address;
          nrd++;
        end
        if (mem_write) begin
          if (nwr == 0) begin
            wb_addr = mem_address;
            wb_data = mem_writedata;
          end
          nwr++;
        end
        @(posedge clk); #1;
      end else begin
        got_rd = readdata;
        done = 1;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;

    check("stall", 32'(stall), 32'(exp_stall));
    if (!wr) check("rdata", 32'(got_rd), 32'(exp_rd));
    check("mrd_cyc", 32'(nrd), exp_hit ? 32'd0 : 32'(MEM_LAT + 1));
    check("mwr_cyc", 32'(nwr), exp_dirty ? 32'(MEM_LAT + 1) : 32'd0);
    if (!exp_hit) check("mrd_addr", 32'(rd_addr), 32'({tg, idx}));
    if (exp_dirty) begin
      check("wb_addr", 32'(wb_addr), 32'(exp_wb_addr));
      check("wb_data", wb_data, exp_wb_data);
      check("mem_img", mem[exp_wb_addr], exp_wb_data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         op;

    for (int i = 0; i < 64; i++) init_val[i] = $urandom;
    init_val[0] = 32'h0403_0201;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val[i];
    ref_reset();

    RESET = 1'b1; load_mem = 1'b1;
    read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    @(posedge clk); @(negedge clk);
    read = 1'b1; write = 1'b1;
    #1;
    check("rst_busy", 32'(busywait), 32'd0);
    check("rst_mrd", 32'(mem_read), 32'd0);
    check("rst_mwr", 32'(mem_write), 32'd0);
    check("rst_rdata", 32'(readdata), 32'd0);
    check("rst_maddr", 32'(mem_address), 32'd0);
    check("rst_mwdata", mem_writedata, 32'd0);
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    RESET = 1'b0; load_mem = 1'b0;

    // Clean miss, then hit on the same block
    access(1'b0, 1'b1, 8'h00, 8'h00);
    access(1'b0, 1'b1, 8'h03, 8'h00);
    // Write hit then read back
    access(1'b1, 1'b0, 8'h01, 8'hAA);
    access(1'b0, 1'b1, 8'h01, 8'h00);
    // Dirty eviction of index 0
    access(1'b0, 1'b1, 8'h20, 8'h00);
    // Write miss, read back, then evict it
    access(1'b1, 1'b0, 8'h44, 8'h5C);
    access(1'b0, 1'b1, 8'h44, 8'h00);
    access(1'b0, 1'b1, 8'h04, 8'h00);

    // Reset in the third MEM_READ cycle abandons the refill
    read = 1'b1; address = 8'h60;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_active", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    RESET = 1'b1;
    @(negedge clk);
    check("rst_mr_mrd", 32'(mem_read), 32'd0);
    check("rst_mr_busy", 32'(busywait), 32'd0);
    @(posedge clk); #1;
    RESET = 1'b0; read = 1'b0;
    ref_reset();
    @(negedge clk);
    check("post_rst_mrd", 32'(mem_read), 32'd0);
    check("post_rst_mwr", 32'(mem_write), 32'd0);
    check("post_rst_busy", 32'(busywait), 32'd0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 8'h60, 8'h00);
    access(1'b0, 1'b1, 8'h00, 8'h00);

    // read and write together on a hit acts as a store
    access(1'b1, 1'b1, 8'h61, 8'h3C);
    access(1'b0, 1'b1, 8'h61, 8'h00);
    access(1'b0, 1'b1, 8'h00, 8'h00);

    for (int n = 0; n < 150; n++) begin
      a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom)};
      op = $urandom_range(0, 2);
      case (op)
        0:       access(1'b0, 1'b1, a, 8'h00);
        1:       access(1'b1, 1'b0, a, 8'($urandom));
        default: access(1'b1, 1'b1, a, 8'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

- Direct-mapped, write-back, write-allocate data cache with its controller FSM.
- Sits between the 8-bit CPU datapath (the loadbyte/storebyte path fed by the ALU result as address) and the word-wide data memory.
- Serves hits with no stall. On a miss it stalls the CPU through `busywait` while it sequences write-back and refill against the memory's busywait handshake.
- Geometry: 8 blocks × 4 bytes. Address split: tag = `address[7:5]`, index = `address[4:2]`, offset = `address[1:0]`.

## Interface

Parameters:
- None. Geometry is fixed.

Ports:
- `CLK` — input, 1 — single clock; all state updates on the rising edge.
- `RESET` — input, 1 — synchronous, active-high reset.
- `read` — input, 1 — CPU load request.
- `write` — input, 1 — CPU store request. Has priority if asserted together with `read`.
- `address` — input, 8 — CPU byte address. Held stable by the CPU while `busywait` is high.
- `writedata` — input, 8 — store data.
- `readdata` — output, 8 — load data.
- `busywait` — output, 1 — CPU stall request.
- `mem_read` — output, 1 — memory block read request.
- `mem_write` — output, 1 — memory block write request.
- `mem_address` — output, 6 — block address `{tag, index}`.
- `mem_writedata` — output, 32 — block being written back. Byte 0 is in `[7:0]`.
- `mem_readdata` — input, 32 — refill block. Byte 0 is in `[7:0]`.
- `mem_busywait` — input, 1 — memory is busy with the current request.

## Operation

Storage, per block:
- 32-bit data
- 3-bit tag
- valid bit
- dirty bit

Hit:
- hit = valid[index] && tag[index] == `address[7:5]`, evaluated combinationally.

States: IDLE, WRITE_BACK, MEM_READ, UPDATE.

IDLE:
- `busywait` = (`read` | `write`) & ~hit.
- Read hit: `readdata` = byte `offset` of block `index`, combinationally. Otherwise `readdata` = 8'h00.
- Write hit: at the rising edge, write `writedata` into byte `offset` and set dirty = 1.
- Miss with valid & dirty: go to WRITE_BACK.
- Miss otherwise: go to MEM_READ.

WRITE_BACK:
- `mem_write` = 1, `mem_address` = {stored tag, index}, `mem_writedata` = stored block. `busywait` = 1.
- At the first edge with `mem_busywait` = 0: go to MEM_READ.

MEM_READ:
- `mem_read` = 1, `mem_address` = {`address[7:5]`, index}. `busywait` = 1.
- At the first edge with `mem_busywait` = 0: go to UPDATE.

UPDATE (one cycle):
- `mem_read` = `mem_write` = 0, `busywait` = 1.
- At the edge: block ← `mem_readdata` (latched at MEM_READ completion), tag ← `address[7:5]`, valid = 1, dirty = 0. Go to IDLE.
- In IDLE the request is now a hit and is served as above.

Memory handshake:
- The memory raises `mem_busywait` in the same cycle a request appears and holds it until done.
- Completion is sampled as `mem_busywait` = 0 while the request is asserted. The controller drops or changes the request in the next cycle.
- The WRITE_BACK→MEM_READ transition presents a new request back-to-back.

Boundary rules:
- `read` and `write` both high: handled as a write.
- No request in IDLE: no state change, no array update.
- `address`/`writedata` changing while `busywait` = 1: protocol violation; behaviour unspecified.

## Timing

Reset:
- `RESET` high at an edge: state ← IDLE, all valid and dirty bits ← 0, latched refill data ← 0. Tags and data are don't-care.
- This applies from any state, including mid-WRITE_BACK and mid-MEM_READ; the memory transfer is abandoned.
- While `RESET` is high: `busywait`, `mem_read`, `mem_write` = 0, `readdata` = 8'h00, `mem_address` = 0, `mem_writedata` = 0.

Latency, with memory busy for L cycles per request:
- Hit: 0 stall cycles.
- Clean miss: `busywait` high for L+3 cycles (IDLE detect 1, MEM_READ L+1, UPDATE 1). Data is valid in the following cycle with `busywait` low.
- Dirty miss: `busywait` high for 2L+4 cycles.

Output decode:
- `mem_read`/`mem_write` are decoded from registered state only and never glitch within a cycle.
- `busywait` is combinational only in IDLE.

## Test plan

Bench memory: `mem_busywait` high for L = 5 cycles from the first cycle of each new request.

- Reset, then read 0x00 → `busywait` high for 8 cycles, one `mem_read` with `mem_address` = 0x00. After 0x04030201 is returned: `readdata` = 8'h01, then read 0x03 is a hit with 8'h04 and 0 stall.
- Write 0xAA to 0x01 after the block is resident → no stall. Then read 0x01 → 8'hAA with no memory request.
- Dirty eviction: the block at index 0 is dirty (tag 0); read 0x20 → `mem_write` with `mem_address` = 0x00 and `mem_writedata[15:8]` = 8'hAA for 6 cycles, then `mem_read` with `mem_address` = 0x08. `busywait` high for 14 cycles total.
- Write miss to clean index 0x44 → refill from `mem_address` = 0x11, then the byte write. A following read of 0x44 returns the written value and the block is marked dirty (later eviction writes it back).
- `RESET` asserted in the 3rd cycle of MEM_READ → next cycle `mem_read` = 0, `busywait` = 0, state IDLE. A subsequent read of the same address misses again.
- `read` and `write` both high on a hit → byte written, dirty set, no stall.
